// File: rtl/fpu_issue.sv
// fpu_issue: one-at-a-time FPU request issuer with watchdog and flush.
// Ports: req_* in (valid/ready), fpu_* start/done, resp_* out, busy.
module fpu_issue #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [31:0]      fpu_A,
  output logic [31:0]      fpu_B,
  output logic [1:0]       fpu_op,
  output logic             fpu_start,
  input  logic [31:0]      fpu_R,
  input  logic             fpu_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [31:0]   QNAN     = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             accept;

  assign req_ready  = (state_q == S_IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign fpu_start  = (state_q == S_ISSUE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign fpu_A      = a_q;
  assign fpu_B      = b_q;
  assign fpu_op     = op_q;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          tag_d   = req_tag;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // start is already out, so a flush must still drain its done
        cnt_d   = '0;
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = fpu_done ? S_IDLE : S_DRAIN;
        end else if (fpu_done) begin
          data_d  = fpu_R;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = QNAN;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (fpu_done || cnt_q == CNT_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule
